// File: rtl/inst_fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues sequential word fetches,
// buffers in-order responses in a {pc,inst} FIFO and hands the head to decode.
module inst_fetch_queue #(
   parameter int                ADDR_W   = 64,
   parameter int                INST_W   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] PC_START = 'h8000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              transfer_en_i,
   input  logic [ADDR_W-1:0] transfer_pc_i,
   output logic              imem_req_valid_o,
   input  logic              imem_req_ready_i,
   output logic [ADDR_W-1:0] imem_req_addr_o,
   input  logic              imem_resp_valid_i,
   input  logic [INST_W-1:0] imem_resp_inst_i,
   output logic              if_valid_o,
   input  logic              if_ready_i,
   output logic [ADDR_W-1:0] if_pc_o,
   output logic [INST_W-1:0] if_inst_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] fifo_pc   [DEPTH];
   logic [INST_W-1:0] fifo_inst [DEPTH];
   logic [ADDR_W-1:0] tag_pc    [DEPTH];
   logic [PTR_W-1:0]  head, tail, tag_head, tag_tail;
   logic [CNT_W-1:0]  count, outstanding, discard;
   logic [CNT_W:0]    credit_sum;
   logic              req_fire, push, pop;

   // Buffered plus in-flight entries never exceed DEPTH, so a response always finds room.
   assign credit_sum       = {1'b0, count} + {1'b0, outstanding};
   assign imem_req_valid_o = !rst && !transfer_en_i && (credit_sum < {1'b0, FULL});
   assign imem_req_addr_o  = pc_q;
   assign req_fire         = imem_req_valid_o && imem_req_ready_i;

   assign push = imem_resp_valid_i && (discard == '0) && !transfer_en_i;
   assign pop  = if_valid_o && if_ready_i && !transfer_en_i;

   assign if_valid_o = (count != '0);
   assign if_pc_o    = if_valid_o ? fifo_pc[head]   : '0;
   assign if_inst_o  = if_valid_o ? fifo_inst[head] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= PC_START;
      end else if (transfer_en_i) begin
         pc_q <= transfer_pc_i;
      end else if (req_fire) begin
         pc_q <= pc_q + ADDR_W'(4);
      end
   end

   always_ff @(posedge clk) begin
      if (req_fire) begin
         tag_pc[tag_tail] <= pc_q;
      end
      if (push) begin
         fifo_pc[tail]   <= tag_pc[tag_head];
         fifo_inst[tail] <= imem_resp_inst_i;
      end
   end

   // Tags follow every request, stale ones included, so they stay aligned with responses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_head    <= '0;
         tag_tail    <= '0;
         outstanding <= '0;
      end else begin
         if (req_fire) begin
            tag_tail <= tag_tail + PTR_W'(1);
         end
         if (imem_resp_valid_i) begin
            tag_head <= tag_head + PTR_W'(1);
         end
         unique case ({req_fire, imem_resp_valid_i})
            2'b10:   outstanding <= outstanding + CNT_W'(1);
            2'b01:   outstanding <= outstanding - CNT_W'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

   // Earlier stale requests are already inside outstanding, so a redirect reloads discard.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         discard <= '0;
      end else if (transfer_en_i) begin
         discard <= outstanding - CNT_W'(imem_resp_valid_i);
      end else if (imem_resp_valid_i && (discard != '0)) begin
         discard <= discard - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (transfer_en_i) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            tail <= tail + PTR_W'(1);
         end
         if (pop) begin
            head <= head + PTR_W'(1);
         end
         unique case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   a_count_max:   assert property (@(posedge clk) disable iff (rst) count <= FULL);
   a_outst_max:   assert property (@(posedge clk) disable iff (rst) outstanding <= FULL);
   a_discard_max: assert property (@(posedge clk) disable iff (rst) discard <= outstanding);
   a_no_orphan:   assert property (@(posedge clk) disable iff (rst) imem_resp_valid_i |-> outstanding != '0);
   a_no_overfill: assert property (@(posedge clk) disable iff (rst) push |-> (count != FULL) || pop);

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: fixed-latency memory model, PC/instruction scoreboard,
// a per-cycle vector table for the stall/drain case and directed redirect/reset sequences.
module tb_inst_fetch_queue;

   localparam logic [63:0] START = 64'h8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        transfer_en = 1'b0;
   logic [63:0] transfer_pc = '0;
   logic        req_valid;
   logic        req_ready = 1'b0;
   logic [63:0] req_addr;
   logic        resp_valid;
   logic [31:0] resp_inst;
   logic        if_valid;
   logic        if_ready = 1'b0;
   logic [63:0] if_pc;
   logic [31:0] if_inst;

   int          checks = 0;
   int          errors = 0;
   int          mem_lat = 1;
   logic [63:0] sb [$];
   logic [63:0] model_pc = START;

   logic [3:0]  pipe_v;
   logic [63:0] pipe_a [4];

   typedef struct {
      logic req_ready;
      logic if_ready;
      logic exp_req_valid;
      logic exp_if_valid;
   } vec_t;
   vec_t vecs [14];

   always #5 clk = ~clk;

   inst_fetch_queue dut (
      .clk               (clk),
      .rst               (rst),
      .transfer_en_i     (transfer_en),
      .transfer_pc_i     (transfer_pc),
      .imem_req_valid_o  (req_valid),
      .imem_req_ready_i  (req_ready),
      .imem_req_addr_o   (req_addr),
      .imem_resp_valid_i (resp_valid),
      .imem_resp_inst_i  (resp_inst),
      .if_valid_o        (if_valid),
      .if_ready_i        (if_ready),
      .if_pc_o           (if_pc),
      .if_inst_o         (if_inst)
   );

   function automatic logic [31:0] inst_of(input logic [63:0] a);
      return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
   endfunction

   // Memory answers in order after mem_lat cycles and is cleared by the shared reset.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_v <= '0;
      end else begin
         pipe_v    <= {pipe_v[2:0], req_valid && req_ready};
         pipe_a[0] <= req_addr;
         for (int i = 1; i < 4; i++) pipe_a[i] <= pipe_a[i-1];
      end
   end
   assign resp_valid = pipe_v[mem_lat-1];
   assign resp_inst  = inst_of(pipe_a[mem_lat-1]);

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic failNote(input string name, input string msg);
      checks++;
      errors++;
      $display("[TB] FAIL %s %s", name, msg);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic te, input logic [63:0] tp, input logic rr, input logic ir);
      transfer_en = te;
      transfer_pc = tp;
      req_ready   = rr;
      if_ready    = ir;
   endtask

   task automatic doReset(input int lat, input logic ir);
      rst = 1'b1;
      mem_lat = lat;
      applyStimulus(1'b0, '0, 1'b1, ir);
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic waitDelivery(input int max_cycles, input logic [63:0] exp_pc, input string name);
      for (int i = 0; i < max_cycles; i++) begin
         @(negedge clk);
         if (if_valid) begin
            checkOutput(name, if_pc, exp_pc);
            return;
         end
         tick();
      end
      failNote(name, "timeout waiting for if_valid");
   endtask

   // Redirect on a steady-state cycle that also carries a response and a decode pop.
   task automatic redirectCheck(input logic [63:0] target, input string name);
      applyStimulus(1'b1, target, 1'b1, 1'b1);
      @(negedge clk);
      checkOutput({name, "_pre_if_valid"}, 64'(if_valid), 64'd1);
      checkOutput({name, "_pre_resp"}, 64'(resp_valid), 64'd1);
      tick();
      applyStimulus(1'b0, '0, 1'b1, 1'b1);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         checkOutput({name, "_empty"}, 64'(if_valid), 64'd0);
         tick();
      end
      @(negedge clk);
      checkOutput({name, "_valid"}, 64'(if_valid), 64'd1);
      checkOutput({name, "_pc"}, if_pc, target);
      checkOutput({name, "_inst"}, 64'(if_inst), 64'(inst_of(target)));
      tick();
   endtask

   // Scoreboard: expected PCs are queued when a request handshake is seen and retired on decode pops.
   always @(negedge clk) begin
      if (rst) begin
         checkOutput("rst_req_valid", 64'(req_valid), 64'd0);
         checkOutput("rst_if_valid", 64'(if_valid), 64'd0);
         checkOutput("rst_if_pc", if_pc, 64'd0);
         sb.delete();
         model_pc = START;
      end else if (transfer_en) begin
         checkOutput("redirect_req_valid", 64'(req_valid), 64'd0);
         sb.delete();
         model_pc = transfer_pc;
      end else begin
         if (!if_valid) begin
            checkOutput("empty_if_inst", 64'(if_inst), 64'd0);
         end
         if (if_valid && if_ready) begin
            if (sb.size() == 0) begin
               failNote("sb_underflow", $sformatf("unexpected pc=%h", if_pc));
            end else begin
               logic [63:0] exp_pc;
               exp_pc = sb.pop_front();
               checkOutput("deliver_pc", if_pc, exp_pc);
               checkOutput("deliver_inst", 64'(if_inst), 64'(inst_of(exp_pc)));
            end
         end
         if (req_valid && req_ready) begin
            checkOutput("req_addr", req_addr, model_pc);
            sb.push_back(model_pc);
            model_pc = model_pc + 64'd4;
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      for (int i = 0; i < 14; i++) begin
         vecs[i].req_ready     = 1'b1;
         vecs[i].if_ready      = (i >= 10);
         vecs[i].exp_req_valid = (i <= 3) || (i >= 11);
         vecs[i].exp_if_valid  = (i >= 2);
      end

      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      repeat (3) tick();
      @(negedge clk);
      checkOutput("reset_if_pc", if_pc, 64'd0);
      tick();
      rst = 1'b0;

      $display("[TB] stall then drain, 1-cycle memory");
      for (int i = 0; i < 14; i++) begin
         applyStimulus(1'b0, '0, vecs[i].req_ready, vecs[i].if_ready);
         @(negedge clk);
         checkOutput($sformatf("vec%0d_req_valid", i), 64'(req_valid), 64'(vecs[i].exp_req_valid));
         checkOutput($sformatf("vec%0d_if_valid", i), 64'(if_valid), 64'(vecs[i].exp_if_valid));
         tick();
      end

      $display("[TB] random handshakes");
      for (int i = 0; i < 150; i++) begin
         applyStimulus(1'b0, '0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         tick();
      end

      $display("[TB] redirect with two in flight, 2-cycle memory");
      doReset(2, 1'b1);
      repeat (8) tick();
      redirectCheck(64'h8000_0100, "t3");
      repeat (8) tick();
      redirectCheck(64'h8000_0180, "t4");
      repeat (8) tick();

      $display("[TB] back-to-back redirects");
      applyStimulus(1'b1, 64'h8000_0200, 1'b1, 1'b1);
      tick();
      applyStimulus(1'b1, 64'h8000_0300, 1'b1, 1'b1);
      tick();
      applyStimulus(1'b0, '0, 1'b1, 1'b1);
      @(negedge clk);
      checkOutput("t5_req_valid", 64'(req_valid), 64'd1);
      checkOutput("t5_req_addr", req_addr, 64'h8000_0300);
      tick();
      waitDelivery(10, 64'h8000_0300, "t5_first_pc");
      tick();

      $display("[TB] reset mid-operation");
      doReset(2, 1'b0);
      repeat (4) tick();
      @(negedge clk);
      checkOutput("t6_credit_req_valid", 64'(req_valid), 64'd0);
      checkOutput("t6_pre_if_valid", 64'(if_valid), 64'd1);
      #1 rst = 1'b1;
      #1;
      checkOutput("t6_async_if_valid", 64'(if_valid), 64'd0);
      checkOutput("t6_async_req_valid", 64'(req_valid), 64'd0);
      checkOutput("t6_async_if_pc", if_pc, 64'd0);
      tick();
      tick();
      applyStimulus(1'b0, '0, 1'b1, 1'b1);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("t6_restart_valid", 64'(req_valid), 64'd1);
      checkOutput("t6_restart_addr", req_addr, START);
      tick();
      waitDelivery(10, START, "t6_first_pc");
      tick();

      $display("[TB] pc wrap and unaligned target");
      repeat (4) tick();
      applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 1'b1);
      tick();
      applyStimulus(1'b0, '0, 1'b1, 1'b1);
      repeat (12) tick();
      applyStimulus(1'b1, 64'h8000_0102, 1'b1, 1'b1);
      tick();
      applyStimulus(1'b0, '0, 1'b1, 1'b1);
      repeat (10) tick();

      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      repeat (10) tick();
      @(negedge clk);
      checkOutput("sb_drained", 64'(sb.size()), 64'd0);
      checkOutput("final_if_valid", 64'(if_valid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
